fc_input_buffer: RTL and testbench

Deserialising input buffer for the fully-connected stage. It accepts the flattened pool-layer activation stream one WIDTH-bit word per beat and assembles IN words into a frame. It then presents the frame as the parallel `x[0:IN-1]` vector that the combinational `layer` neuron bank consumes. The buffer holds two frames, one filling and one presented, so the producer can stream the next frame while `layer` evaluates the current one.

---
 rtl/fc_pkg.sv | 16 +
 rtl/fc_input_buffer_if.sv | 27 ++
 rtl/fc_input_buffer_frame_ctrl.sv | 106 ++++++++++
 rtl/fc_input_buffer.sv | 63 ++++++
 tb/tb_fc_input_buffer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared constants and types for the fully-connected stage input path.
package fc_pkg;

  localparam int FC1_IN    = 400;
  localparam int ACT_WIDTH = 8;

  typedef logic [ACT_WIDTH-1:0] act_t;

  // Encoded as {pending, x_valid}; 2'b10 has no meaning and is never entered.
  typedef enum logic [1:0] {
    FC_EMPTY     = 2'b00,
    FC_PRESENTED = 2'b01,
    FC_FULL      = 2'b11
  } fc_state_e;

endpackage

// File: rtl/fc_input_buffer_if.sv
// Activation stream in, parallel frame out, for the fully-connected input buffer.
interface fc_input_buffer_if
  import fc_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH,
  parameter int IN    = FC1_IN
);

  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;

  modport master (
    output s_data, s_valid, s_last, x_ready,
    input  s_ready, x, x_valid
  );

  modport slave (
    input  s_data, s_valid, s_last, x_ready,
    output s_ready, x, x_valid
  );

endinterface

// File: rtl/fc_input_buffer_frame_ctrl.sv
// Word counter, framing check and two-slot occupancy control for fc_input_buffer.
module frame_ctrl
  import fc_pkg::*;
#(
  parameter int IN = FC1_IN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic                  s_last,
  input  logic                  x_ready,
  output logic                  s_ready,
  output logic                  x_valid,
  output logic                  pending,
  output logic                  wr_en,
  output logic                  copy_en,
  output logic                  err,
  output logic [$clog2(IN)-1:0] idx
);

  localparam int              IDX_W    = $clog2(IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  fc_state_e        state_r;
  fc_state_e        state_nx_s;
  logic [IDX_W-1:0] idx_r;
  logic             s_ready_r;
  logic             err_r;
  logic             accept_s;
  logic             at_end_s;
  logic             done_s;
  logic             ferr_s;
  logic             release_s;

  assign accept_s  = s_valid && s_ready_r;
  assign at_end_s  = (idx_r == LAST_IDX);
  assign done_s    = accept_s && at_end_s && s_last;
  assign ferr_s    = accept_s && (s_last != at_end_s);
  assign release_s = (state_r != FC_EMPTY) && x_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FC_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Occupancy next-state: completion fills a slot, release frees one.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      FC_EMPTY: begin
        if (done_s) state_nx_s = FC_PRESENTED;
        else        state_nx_s = FC_EMPTY;
      end
      FC_PRESENTED: begin
        if (done_s && release_s)      state_nx_s = FC_PRESENTED;
        else if (done_s)              state_nx_s = FC_FULL;
        else if (release_s)           state_nx_s = FC_EMPTY;
        else                          state_nx_s = FC_PRESENTED;
      end
      FC_FULL: begin
        if (release_s) state_nx_s = FC_PRESENTED;
        else           state_nx_s = FC_FULL;
      end
      default: state_nx_s = FC_EMPTY;
    endcase
  end

  // Datapath strobes: write the fill slot, and move fill into the output slot.
  always_comb begin
    wr_en   = accept_s && !ferr_s;
    copy_en = 1'b0;
    case (state_r)
      FC_EMPTY:     copy_en = done_s;
      FC_PRESENTED: copy_en = done_s && release_s;
      FC_FULL:      copy_en = release_s;
      default:      copy_en = 1'b0;
    endcase
  end

  // Word index, sticky framing error and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r     <= {IDX_W{1'b0}};
      err_r     <= 1'b0;
      s_ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        if (done_s || ferr_s) idx_r <= {IDX_W{1'b0}};
        else                  idx_r <= idx_r + IDX_W'(1);
      end
      if (ferr_s) err_r <= 1'b1;
      s_ready_r <= (state_nx_s != FC_FULL);
    end
  end

  assign s_ready = s_ready_r;
  assign x_valid = (state_r != FC_EMPTY);
  assign pending = (state_r == FC_FULL);
  assign err     = err_r;
  assign idx     = idx_r;

endmodule

// File: rtl/fc_input_buffer.sv
// Double-buffered deserialiser: assembles IN activation words into the parallel x frame.
module fc_input_buffer
  import fc_pkg::*;
#(
  parameter int WIDTH = ACT_WIDTH,
  parameter int IN    = FC1_IN
) (
  input  logic               clk,
  input  logic               rst_n,
  fc_input_buffer_if.slave   bus,
  output logic               err
);

  localparam int IDX_W = $clog2(IN);

  logic [WIDTH-1:0] fill_r [0:IN-1];
  logic [WIDTH-1:0] x_r    [0:IN-1];
  logic             wr_en_s;
  logic             copy_en_s;
  logic             pending_s;
  logic             s_ready_s;
  logic             x_valid_s;
  logic [IDX_W-1:0] idx_s;

  frame_ctrl #(
    .IN (IN)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (bus.s_valid),
    .s_last  (bus.s_last),
    .x_ready (bus.x_ready),
    .s_ready (s_ready_s),
    .x_valid (x_valid_s),
    .pending (pending_s),
    .wr_en   (wr_en_s),
    .copy_en (copy_en_s),
    .err     (err),
    .idx     (idx_s)
  );

  // Frame storage is deliberately unreset; x_valid qualifies its contents.
  for (genvar g = 0; g < IN; g++) begin : g_word
    logic hit_s;
    assign hit_s = wr_en_s && (idx_s == IDX_W'(g));

    // Fill slot word g.
    always_ff @(posedge clk) begin
      if (hit_s) fill_r[g] <= bus.s_data;
    end

    // Output slot word g; the word arriving on the completing beat bypasses fill.
    always_ff @(posedge clk) begin
      if (copy_en_s) x_r[g] <= hit_s ? bus.s_data : fill_r[g];
    end

    assign bus.x[g] = x_r[g];
  end

  assign bus.s_ready = s_ready_s;
  assign bus.x_valid = x_valid_s;

endmodule

// File: tb/tb_fc_input_buffer.sv
// Directed bench for fc_input_buffer, checked every cycle against a frame-level model.
module tb_fc_input_buffer;
  import fc_pkg::*;

  localparam int IN = FC1_IN;
  localparam int W  = ACT_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic err;

  fc_input_buffer_if #(.WIDTH(W), .IN(IN)) bus ();

  fc_input_buffer #(.WIDTH(W), .IN(IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a queue of words being gathered, the presented frame, and a held frame.
  logic [W-1:0] fill_q [$];
  logic [W-1:0] m_x    [IN];
  logic [W-1:0] m_pend [IN];
  logic [W-1:0] m_new  [IN];
  bit           m_xv, m_pv, m_err;
  bit           acc, rel, done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gen(input int kind, input int i);
    case (kind)
      0:       return W'(i % 256);
      1:       return 8'hA5;
      2:       return W'((i * 3) % 256);
      default: return W'(255 - (i % 256));
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_xv = 1'b0; m_pv = 1'b0; m_err = 1'b0;
      fill_q.delete();
    end else begin
      acc  = bus.s_valid && !m_pv;
      rel  = m_xv && bus.x_ready;
      done = 1'b0;
      if (acc) begin
        fill_q.push_back(bus.s_data);
        if (bus.s_last || fill_q.size() == IN) begin
          if (bus.s_last && fill_q.size() == IN) begin
            done = 1'b1;
            for (int i = 0; i < IN; i++) m_new[i] = fill_q[i];
          end else begin
            m_err = 1'b1;
          end
          fill_q.delete();
        end
      end
      if (m_pv && rel) begin
        m_x  = m_pend;
        m_pv = 1'b0;
      end else if (done) begin
        if (!m_xv || rel) begin
          m_x  = m_new;
          m_xv = 1'b1;
        end else begin
          m_pend = m_new;
          m_pv   = 1'b1;
        end
      end else if (rel) begin
        m_xv = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    int bad;
    int first;
    @(negedge clk);
    chk("s_ready", 32'(bus.s_ready), 32'(!m_pv));
    chk("x_valid", 32'(bus.x_valid), 32'(m_xv));
    chk("err", 32'(err), 32'(m_err));
    chk("pending_without_x_valid", 32'(dut.pending_s && !bus.x_valid), 32'd0);
    if (m_xv) begin
      bad = 0;
      first = -1;
      for (int i = 0; i < IN; i++) begin
        if (bus.x[i] !== m_x[i]) begin
          bad++;
          if (first < 0) first = i;
        end
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL x_frame: %0d words differ, first x[%0d] got %0h expected %0h at %0t",
                 bad, first, bus.x[first], m_x[first], $time);
      end
    end
  end

  task automatic send_frame(input int n, input int kind, input int last_at, input bit rel_last);
    for (int i = 0; i < n; i++) begin
      int wait_n = 0;
      while (!bus.s_ready && wait_n < 64) begin
        @(posedge clk); #1;
        wait_n++;
      end
      if (!bus.s_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s_ready_timeout: got 0 required 1 at beat %0d", i);
      end
      bus.s_valid = 1'b1;
      bus.s_data  = gen(kind, i);
      bus.s_last  = (i == last_at);
      bus.x_ready = rel_last && (i == n - 1);
      @(posedge clk); #1;
      bus.x_ready = 1'b0;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic pulse_release();
    bus.x_ready = 1'b1;
    @(posedge clk); #1;
    bus.x_ready = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.x_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ready", 32'(bus.s_ready), 32'd1);
    chk("reset_x_valid", 32'(bus.x_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame, x[i] = i mod 256.
    send_frame(IN, 0, IN - 1, 1'b0);
    chk("a_x_valid", 32'(bus.x_valid), 32'd1);
    chk("a_x0", 32'(bus.x[0]), 32'h00);
    chk("a_x255", 32'(bus.x[255]), 32'hFF);
    chk("a_x256", 32'(bus.x[256]), 32'h00);
    chk("a_x399", 32'(bus.x[399]), 32'h8F);
    chk("a_s_ready", 32'(bus.s_ready), 32'd1);

    // Back-pressure: second frame is held until released.
    send_frame(IN, 1, IN - 1, 1'b0);
    chk("b_s_ready_low", 32'(bus.s_ready), 32'd0);
    chk("b_x5_old", 32'(bus.x[5]), 32'h05);
    repeat (3) @(posedge clk);
    #1;
    chk("b_s_ready_still_low", 32'(bus.s_ready), 32'd0);
    pulse_release();
    chk("b_x0_new", 32'(bus.x[0]), 32'hA5);
    chk("b_x399_new", 32'(bus.x[399]), 32'hA5);
    chk("b_s_ready_back", 32'(bus.s_ready), 32'd1);
    chk("b_x_valid", 32'(bus.x_valid), 32'd1);

    // Final beat coincides with release: no x_valid gap.
    send_frame(IN, 2, IN - 1, 1'b1);
    chk("c_x_valid", 32'(bus.x_valid), 32'd1);
    chk("c_x1", 32'(bus.x[1]), 32'h03);
    chk("c_x100", 32'(bus.x[100]), 32'h2C);

    // Early s_last, then a clean frame that ends up held behind frame C.
    send_frame(11, 3, 10, 1'b0);
    chk("e_err", 32'(err), 32'd1);
    chk("e_x1_kept", 32'(bus.x[1]), 32'h03);
    send_frame(IN, 3, IN - 1, 1'b0);
    chk("d_s_ready_low", 32'(bus.s_ready), 32'd0);
    pulse_release();
    chk("d_x0", 32'(bus.x[0]), 32'hFF);
    chk("d_x399", 32'(bus.x[399]), 32'h70);
    pulse_release();
    chk("d_x_valid_cleared", 32'(bus.x_valid), 32'd0);

    // Missing s_last on the final word.
    send_frame(IN, 0, -1, 1'b0);
    chk("m_x_valid", 32'(bus.x_valid), 32'd0);
    chk("m_idx", 32'(dut.idx_s), 32'd0);
    chk("m_err", 32'(err), 32'd1);

    // Reset in the middle of a frame.
    send_frame(200, 0, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_s_ready", 32'(bus.s_ready), 32'd1);
    chk("r_x_valid", 32'(bus.x_valid), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    chk("r_idx", 32'(dut.idx_s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(IN, 2, IN - 1, 1'b0);
    chk("r2_x_valid", 32'(bus.x_valid), 32'd1);
    chk("r2_x2", 32'(bus.x[2]), 32'h06);
    chk("r2_x399", 32'(bus.x[399]), 32'hAD);
    chk("r2_err", 32'(err), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
